// File: rtl/sdram_arb_pkg.sv
// Shared types and the round-robin pick function for the two-master SDRAM arbiter.
package sdram_arb_pkg;

    localparam int NUM_MASTERS = 2;

    typedef logic [0:0] master_id_t;

    typedef struct packed {
        logic       valid;
        master_id_t id;
    } grant_t;

    // The master that did not win last time has priority; otherwise fall back to the other one.
    function automatic grant_t rr_pick(input logic [NUM_MASTERS-1:0] req, input master_id_t last);
        grant_t     g;
        master_id_t other;
        other   = ~last;
        g.valid = 1'b0;
        g.id    = last;
        if (req[other]) begin
            g.valid = 1'b1;
            g.id    = other;
        end else if (req[last]) begin
            g.valid = 1'b1;
            g.id    = last;
        end
        return g;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of master IDs for reads that have been issued but not yet answered.
module arb_id_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  master_id_t               din,
    output master_id_t               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int                 PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]     FULL_CNT = (PTR_W + 1)'(DEPTH);

    master_id_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    // Head is read combinationally so the response can be steered in the beat's own cycle.
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_rr_arbiter.sv
// Two-master Avalon-MM round-robin arbiter in front of the SDRAM controller slave,
// with in-order read response steering through an ID FIFO.
module sdram_rr_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0][ADDR_W-1:0] m_address,
    input  logic [1:0]             m_read,
    input  logic [1:0]             m_write,
    input  logic [1:0][DATA_W-1:0] m_writedata,
    output logic [1:0]             m_waitrequest,
    output logic [DATA_W-1:0]      m_readdata,
    output logic [1:0]             m_readdatavalid,
    output logic [ADDR_W-1:0]      s_address,
    output logic                   s_read,
    output logic                   s_write,
    output logic [DATA_W-1:0]      s_writedata,
    input  logic                   s_waitrequest,
    input  logic [DATA_W-1:0]      s_readdata,
    input  logic                   s_readdatavalid,
    output logic                   err
);

    localparam int CNT_W = $clog2(MAX_PEND) + 1;

    logic              r_lock;
    master_id_t        r_locked_id;
    master_id_t        r_last;
    logic              r_err;

    logic [CNT_W-1:0]  w_pend_cnt;
    logic              w_full;
    logic              w_empty;
    master_id_t        w_head;
    logic [1:0]        w_req;
    grant_t            w_rr;
    grant_t            w_grant;
    logic              w_cmd_write;
    logic              w_cmd_read;
    logic              w_cmd;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
        assign w_req[gi]           = m_write[gi] | (m_read[gi] & ~w_full);
        assign m_waitrequest[gi]   = ~rst_n | ~w_grant.valid
                                   | (w_grant.id != master_id_t'(gi)) | s_waitrequest;
        assign m_readdatavalid[gi] = rst_n & w_pop & (w_head == master_id_t'(gi));
    end

    always_comb begin
        w_rr    = rr_pick(w_req, r_last);
        w_grant = w_rr;
        // A stalled command keeps its grant so address/data stay stable until accepted.
        if (r_lock) begin
            w_grant.valid = 1'b1;
            w_grant.id    = r_locked_id;
        end
    end

    // A master presenting both read and write has its write forwarded; the read is dropped.
    assign w_cmd_write = rst_n & w_grant.valid & m_write[w_grant.id];
    assign w_cmd_read  = rst_n & w_grant.valid & ~m_write[w_grant.id] & m_read[w_grant.id] & ~w_full;
    assign w_cmd       = w_cmd_write | w_cmd_read;
    assign w_accept    = w_cmd & ~s_waitrequest;
    assign w_push      = w_accept & w_cmd_read;
    assign w_pop       = s_readdatavalid & ~w_empty;

    assign s_write     = w_cmd_write;
    assign s_read      = w_cmd_read;
    assign s_address   = m_address[w_grant.id];
    assign s_writedata = m_writedata[w_grant.id];
    assign m_readdata  = s_readdata;
    assign err         = r_err;

    arb_id_fifo #(
        .DEPTH (MAX_PEND)
    ) u_id_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_grant.id),
        .dout  (w_head),
        .count (w_pend_cnt),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= 1'b1;
            r_lock      <= 1'b0;
            r_locked_id <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_lock <= w_cmd & s_waitrequest;
            if (w_cmd && s_waitrequest) begin
                r_locked_id <= w_grant.id;
            end
            if (w_accept) begin
                r_last <= w_grant.id;
            end
            // A response with nothing outstanding means the slave and our ID tracking disagree.
            if (s_readdatavalid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Directed self-checking bench for sdram_rr_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later, registers update on the rising edge.
module tb_sdram_rr_arbiter;

    logic              clk;
    logic              rst_n;
    logic [1:0][31:0]  m_address;
    logic [1:0]        m_read;
    logic [1:0]        m_write;
    logic [1:0][31:0]  m_writedata;
    logic [1:0]        m_waitrequest;
    logic [31:0]       m_readdata;
    logic [1:0]        m_readdatavalid;
    logic [31:0]       s_address;
    logic              s_read;
    logic              s_write;
    logic [31:0]       s_writedata;
    logic              s_waitrequest;
    logic [31:0]       s_readdata;
    logic              s_readdatavalid;
    logic              err;

    int checks = 0;
    int errors = 0;

    sdram_rr_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_PEND (8)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        m_read          = 2'b00;
        m_write         = 2'b00;
        m_address       = '0;
        m_writedata     = '0;
        s_waitrequest   = 1'b0;
        s_readdata      = '0;
        s_readdatavalid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        m_read  = 2'b01;
        m_write = 2'b10;
        s_readdatavalid = 1'b1;
        #1;
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL reset_s_read got %b want 0", s_read); end
        checks++; if (s_write !== 1'b0) begin errors++; $display("FAIL reset_s_write got %b want 0", s_write); end
        checks++; if (m_waitrequest !== 2'b11) begin errors++; $display("FAIL reset_waitreq got %b want 11", m_waitrequest); end
        checks++; if (m_readdatavalid !== 2'b00) begin errors++; $display("FAIL reset_rdvalid got %b want 00", m_readdatavalid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        $display("reset: outputs held idle");
        @(negedge clk);
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        m_read[0] = 1'b1;
        m_address[0] = 32'h100;
        #1;
        checks++; if (s_read !== 1'b1) begin errors++; $display("FAIL single_s_read got %b want 1", s_read); end
        checks++; if (s_address !== 32'h100) begin errors++; $display("FAIL single_addr got %h want 00000100", s_address); end
        checks++; if (m_waitrequest !== 2'b10) begin errors++; $display("FAIL single_waitreq got %b want 10", m_waitrequest); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (m_readdatavalid !== 2'b00) begin errors++; $display("FAIL single_early_rdv got %b want 00", m_readdatavalid); end
        @(negedge clk);
        s_readdatavalid = 1'b1;
        s_readdata      = 32'hDEADBEEF;
        #1;
        checks++; if (m_readdatavalid !== 2'b01) begin errors++; $display("FAIL single_rdv got %b want 01", m_readdatavalid); end
        checks++; if (m_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got %h want deadbeef", m_readdata); end
        $display("single read: m0 addr 100 data %h", m_readdata);
        @(negedge clk);
        idle();
    endtask

    task automatic test_fairness();
        int exp_id;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            m_write        = 2'b11;
            m_address[0]   = 32'hA0;
            m_address[1]   = 32'hB0;
            m_writedata[0] = 32'h1111_0000;
            m_writedata[1] = 32'h2222_0000;
            #1;
            exp_id = k % 2;
            checks++; if (s_write !== 1'b1) begin errors++; $display("FAIL fair_s_write[%0d] got %b want 1", k, s_write); end
            checks++; if (s_address !== (exp_id == 0 ? 32'hA0 : 32'hB0)) begin errors++; $display("FAIL fair_addr[%0d] got %h want m%0d", k, s_address, exp_id); end
            checks++; if (s_writedata !== (exp_id == 0 ? 32'h1111_0000 : 32'h2222_0000)) begin errors++; $display("FAIL fair_wdata[%0d] got %h want m%0d", k, s_writedata, exp_id); end
            checks++; if (m_waitrequest !== (exp_id == 0 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL fair_waitreq[%0d] got %b", k, m_waitrequest); end
            $display("fairness: accept %0d addr %h", k, s_address);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_lock();
        // One lone m0 write first so m1 holds round-robin priority when both request.
        @(negedge clk);
        m_write[0] = 1'b1;
        m_address[0] = 32'h50;
        #1;
        checks++; if (s_address !== 32'h50) begin errors++; $display("FAIL lock_pre_addr got %h want 00000050", s_address); end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            m_write[0]    = 1'b1;
            m_address[0]  = 32'h300;
            m_write[1]    = (c <= 4);
            m_address[1]  = 32'h200;
            s_waitrequest = (c <= 3);
            #1;
            if (c <= 4) begin
                checks++; if (s_address !== 32'h200) begin errors++; $display("FAIL lock_addr[%0d] got %h want 00000200", c, s_address); end
                checks++; if (m_waitrequest[0] !== 1'b1) begin errors++; $display("FAIL lock_m0_stall[%0d] got %b want 1", c, m_waitrequest[0]); end
                checks++; if (m_waitrequest[1] !== (c == 4 ? 1'b0 : 1'b1)) begin errors++; $display("FAIL lock_m1_wait[%0d] got %b", c, m_waitrequest[1]); end
            end else begin
                checks++; if (s_address !== 32'h300) begin errors++; $display("FAIL lock_m0_grant_addr got %h want 00000300", s_address); end
                checks++; if (m_waitrequest !== 2'b10) begin errors++; $display("FAIL lock_m0_grant_wait got %b want 10", m_waitrequest); end
            end
            $display("lock: cycle %0d addr %h waitreq %b", c, s_address, m_waitrequest);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_order();
        logic [1:0]  exp_rdv [3];
        logic [31:0] exp_dat [3];
        exp_rdv[0] = 2'b01; exp_rdv[1] = 2'b10; exp_rdv[2] = 2'b01;
        exp_dat[0] = 32'h11;  exp_dat[1] = 32'h22;  exp_dat[2] = 32'h33;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle();
            m_read[k % 2] = 1'b1;
            m_address[k % 2] = 32'h10 + k;
            #1;
            checks++; if (s_read !== 1'b1 || s_address !== 32'h10 + k) begin errors++; $display("FAIL order_issue[%0d] got read %b addr %h", k, s_read, s_address); end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle();
            s_readdatavalid = 1'b1;
            s_readdata      = exp_dat[k];
            #1;
            checks++; if (m_readdatavalid !== exp_rdv[k]) begin errors++; $display("FAIL order_rdv[%0d] got %b want %b", k, m_readdatavalid, exp_rdv[k]); end
            checks++; if (m_readdata !== exp_dat[k]) begin errors++; $display("FAIL order_rdata[%0d] got %h want %h", k, m_readdata, exp_dat[k]); end
            $display("order: beat %0d rdv %b", k, m_readdatavalid);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_full();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            idle();
            m_read[0] = 1'b1;
            m_address[0] = 32'h1000 + k;
            #1;
            checks++; if (s_read !== 1'b1) begin errors++; $display("FAIL full_fill[%0d] got s_read %b want 1", k, s_read); end
        end
        @(negedge clk);
        m_address[0] = 32'h2000;
        m_write[1]   = 1'b1;
        m_address[1] = 32'h400;
        #1;
        checks++; if (m_waitrequest !== 2'b01) begin errors++; $display("FAIL full_waitreq got %b want 01", m_waitrequest); end
        checks++; if (s_write !== 1'b1 || s_read !== 1'b0 || s_address !== 32'h400) begin errors++; $display("FAIL full_m1_write got w %b r %b addr %h", s_write, s_read, s_address); end
        $display("full: m1 write accepted while m0 read stalled");
        @(negedge clk);
        m_write[1] = 1'b0;
        #1;
        checks++; if (s_read !== 1'b0 || m_waitrequest !== 2'b11) begin errors++; $display("FAIL full_hold got r %b wait %b want 0 11", s_read, m_waitrequest); end
        @(negedge clk);
        s_readdatavalid = 1'b1;
        #1;
        checks++; if (m_readdatavalid !== 2'b01) begin errors++; $display("FAIL full_pop_rdv got %b want 01", m_readdatavalid); end
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL full_pop_same_cycle got s_read %b want 0", s_read); end
        @(negedge clk);
        s_readdatavalid = 1'b0;
        #1;
        checks++; if (s_read !== 1'b1 || s_address !== 32'h2000 || m_waitrequest[0] !== 1'b0) begin errors++; $display("FAIL full_reissue got r %b addr %h wait %b", s_read, s_address, m_waitrequest); end
        $display("full: m0 read issued after pop");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            idle();
            s_readdatavalid = 1'b1;
            #1;
            checks++; if (m_readdatavalid !== 2'b01) begin errors++; $display("FAIL full_drain[%0d] got %b want 01", k, m_readdatavalid); end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_error_reset();
        @(negedge clk);
        s_readdatavalid = 1'b1;
        #1;
        checks++; if (m_readdatavalid !== 2'b00) begin errors++; $display("FAIL err_empty_rdv got %b want 00", m_readdatavalid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_before got %b want 0", err); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err); end
        @(negedge clk);
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
        $display("error: empty response flagged");
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            m_read[0] = 1'b1;
            m_address[0] = 32'h500 + 4 * k;
            #1;
            checks++; if (s_read !== 1'b1) begin errors++; $display("FAIL burst_read[%0d] got %b want 1", k, s_read); end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err got %b want 0", err); end
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL midrst_s_read got %b want 0", s_read); end
        checks++; if (m_waitrequest !== 2'b11) begin errors++; $display("FAIL midrst_waitreq got %b want 11", m_waitrequest); end
        $display("reset: mid-burst reset cleared state");
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        s_readdatavalid = 1'b1;
        #1;
        checks++; if (m_readdatavalid !== 2'b00) begin errors++; $display("FAIL stale_rdv got %b want 00", m_readdatavalid); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL stale_err got %b want 1", err); end
        $display("error: stale response after reset flagged");
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_single_read();
        test_fairness();
        test_lock();
        test_order();
        test_full();
        test_error_reset();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
